// File: rtl/alarm_sequencer.sv
// alarm_sequencer: receives the comparator's sound_alarm level, rings a
// square-wave buzzer on its rising edge, and handles snooze, stop and an
// automatic ring timeout counted in sec_tick strobes.
// Optional build macro: ALARM_BEEP_EN gates the tone with a 1 s on / 1 s off
// beep cadence while ringing.
module alarm_sequencer #(
  parameter int TONE_DIV    = 4,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sound_alarm,
  input  logic       alarm_enable,
  input  logic       sec_tick,
  input  logic       snooze_btn,
  input  logic       stop_btn,
  output logic       buzzer,
  output logic       alarm_active,
  output logic       snoozing,
  output logic [3:0] snooze_left
);

  // Widths hold 0..PARAM-1; a parameter of 1 still needs one bit.
  localparam int TW = (TONE_DIV    > 1) ? $clog2(TONE_DIV)    : 1;
  localparam int RW = (RING_SECS   > 1) ? $clog2(RING_SECS)   : 1;
  localparam int SW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;

  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECS - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SECS - 1);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  state_t        state;
  logic          sa_prev;
  logic          tone;
  logic [TW-1:0] tone_cnt;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snz_cnt;
  logic          trigger;
  logic          tone_nxt;
  logic          gate_nxt;

`ifdef ALARM_BEEP_EN
  logic          beep_phase;
`endif

  // Rising edge of the match level and the next tone / gate values while ringing.
  always_comb begin
    trigger  = sound_alarm & ~sa_prev;
    tone_nxt = tone ^ (tone_cnt == TONE_LAST);
`ifdef ALARM_BEEP_EN
    gate_nxt = beep_phase ^ sec_tick;
`else
    gate_nxt = 1'b1;
`endif
  end

  // Sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sa_prev      <= 1'b1;
      tone         <= 1'b0;
      tone_cnt     <= '0;
      ring_cnt     <= '0;
      snz_cnt      <= '0;
      buzzer       <= 1'b0;
      alarm_active <= 1'b0;
      snoozing     <= 1'b0;
      snooze_left  <= 4'd0;
`ifdef ALARM_BEEP_EN
      beep_phase   <= 1'b0;
`endif
    end else begin
      sa_prev <= sound_alarm;
      if (stop_btn || !alarm_enable) begin
        // Stop and disarm override everything else; snooze_left is kept.
        state        <= IDLE;
        tone         <= 1'b0;
        tone_cnt     <= '0;
        ring_cnt     <= '0;
        snz_cnt      <= '0;
        buzzer       <= 1'b0;
        alarm_active <= 1'b0;
        snoozing     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (trigger) begin
              state        <= RINGING;
              snooze_left  <= 4'(MAX_SNOOZE);
              ring_cnt     <= '0;
              tone_cnt     <= '0;
              tone         <= 1'b0;
              buzzer       <= 1'b0;
              alarm_active <= 1'b1;
`ifdef ALARM_BEEP_EN
              beep_phase   <= 1'b1;
`endif
            end
          end
          RINGING: begin
            if (snooze_btn && snooze_left != 4'd0) begin
              state        <= SNOOZE;
              snooze_left  <= snooze_left - 4'd1;
              snz_cnt      <= '0;
              ring_cnt     <= '0;
              tone_cnt     <= '0;
              tone         <= 1'b0;
              buzzer       <= 1'b0;
              alarm_active <= 1'b0;
              snoozing     <= 1'b1;
            end else if (sec_tick && ring_cnt == RING_LAST) begin
              state        <= IDLE;
              ring_cnt     <= '0;
              tone_cnt     <= '0;
              tone         <= 1'b0;
              buzzer       <= 1'b0;
              alarm_active <= 1'b0;
            end else begin
              // Keep ringing: advance the tone divider and the second count.
              tone     <= tone_nxt;
              tone_cnt <= (tone_cnt == TONE_LAST) ? '0 : tone_cnt + 1'b1;
              buzzer   <= tone_nxt & gate_nxt;
              if (sec_tick) ring_cnt <= ring_cnt + 1'b1;
`ifdef ALARM_BEEP_EN
              beep_phase <= gate_nxt;
`endif
            end
          end
          SNOOZE: begin
            if (sec_tick) begin
              if (snz_cnt == SNZ_LAST) begin
                state        <= RINGING;
                snz_cnt      <= '0;
                ring_cnt     <= '0;
                tone_cnt     <= '0;
                tone         <= 1'b0;
                buzzer       <= 1'b0;
                alarm_active <= 1'b1;
                snoozing     <= 1'b0;
`ifdef ALARM_BEEP_EN
                beep_phase   <= 1'b1;
`endif
              end else begin
                snz_cnt <= snz_cnt + 1'b1;
              end
            end
          end
          default: begin
            state        <= IDLE;
            buzzer       <= 1'b0;
            alarm_active <= 1'b0;
            snoozing     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
